segment_char_sequencer: RTL and testbench

//  Producer end of the 7-seg character handshake consumed by segment_animator.

---
 rtl/segment_char_sequencer_pkg.sv | 19 +
 rtl/segment_char_sequencer_hex_to_7seg.sv | 11 +
 rtl/segment_char_sequencer.sv | 108 ++++++++++
 tb/tb_segment_char_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_char_sequencer_pkg.sv
// segment_char_sequencer_pkg: shared state encoding, message depth and hex-to-7-seg table
// for the character sequencer.
package segment_char_sequencer_pkg;

    localparam int MSG_DEPTH = 8;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, DWELL} state_t;

    // Entry [d] is the a..g pattern (bit0=a) for hex digit d, listed F down to 0.
    localparam logic [15:0][6:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex7(input logic [3:0] d);
        return HEX7[d];
    endfunction

endpackage

// File: rtl/segment_char_sequencer_hex_to_7seg.sv
// hex_to_7seg: combinational hex digit to active-high 7-segment pattern decoder.
module hex_to_7seg
    import segment_char_sequencer_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = hex7(digit);

endmodule

// File: rtl/segment_char_sequencer.sv
// segment_char_sequencer: plays a short hex message one 7-seg character at a time,
// strobing charAvailable per digit and pacing digits by clk60 ticks.
module segment_char_sequencer
    import segment_char_sequencer_pkg::*;
#(
    parameter int PULSE_CLKS = 4,
    parameter int CHAR_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clk60,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [3:0] msg_len,
    input  logic       loop,
    input  logic       start,
    input  logic       stop,
    output logic       charAvailable,
    output logic [6:0] charOutput,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(PULSE_CLKS + 1);
    localparam int TW = $clog2(CHAR_TICKS + 1);

    state_t        state;
    logic [3:0]    msg_buf [MSG_DEPTH];
    logic [2:0]    index;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] tick_cnt;
    logic          clk60_prev;
    logic [3:0]    eff_len;
    logic          tick;
    logic          last;
    logic [6:0]    seg;

    assign eff_len = (msg_len > 4'd8) ? 4'd8 : msg_len;
    assign tick    = clk60 & ~clk60_prev;
    // A length that shrank below the current position also counts as the last digit.
    assign last    = ({1'b0, index} + 4'd1) >= eff_len;
    assign busy    = state != IDLE;

    hex_to_7seg u_dec (
        .digit(msg_buf[index]),
        .seg  (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            pulse_cnt     <= '0;
            tick_cnt      <= '0;
            clk60_prev    <= 1'b0;
            charAvailable <= 1'b0;
            charOutput    <= '0;
            done          <= 1'b0;
            for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= '0;
        end else if (enable) begin
            clk60_prev <= clk60;
            done       <= 1'b0;
            if (wr_en) msg_buf[wr_addr] <= wr_data;
            if ((state == STROBE || state == DWELL) && tick && tick_cnt != CHAR_TICKS[TW-1:0])
                tick_cnt <= tick_cnt + 1'b1;
            if (stop && state != IDLE) begin
                charAvailable <= 1'b0;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start && !stop && eff_len != 4'd0) begin
                        index <= '0;
                        state <= LOAD;
                    end
                    LOAD: begin
                        charOutput <= seg;
                        pulse_cnt  <= '0;
                        tick_cnt   <= '0;
                        state      <= STROBE;
                    end
                    STROBE: if (pulse_cnt != PULSE_CLKS[PW-1:0]) begin
                        charAvailable <= 1'b1;
                        pulse_cnt     <= pulse_cnt + 1'b1;
                    end else begin
                        charAvailable <= 1'b0;
                        state         <= DWELL;
                    end
                    DWELL: if (tick_cnt == CHAR_TICKS[TW-1:0]) begin
                        if (!last) begin
                            index <= index + 3'd1;
                            state <= LOAD;
                        end else if (loop && eff_len != 4'd0) begin
                            index <= '0;
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_segment_char_sequencer.sv
// tb_segment_char_sequencer: scenario tasks driving segment_char_sequencer with random
// clk60 pacing and random messages, checked against an event-level playback model.
module tb_segment_char_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clk60 = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] msg_len = '0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       charAvailable;
    logic [6:0] charOutput;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] model_buf [8] = '{default: 4'd0};

    // Monitor observations: characters at each rise, pulse widths, clk60 ticks between rises.
    logic [6:0] seen [$];
    int         widths [$];
    int         gaps [$];
    int         dones = 0;
    int         busy_at_done = 0;
    int         unstable = 0;
    int         cur_w = 0;
    int         cur_ticks = 0;
    bit         have_rise = 0;
    logic       p60 = 1'b0;
    logic       pca = 1'b0;
    logic [6:0] pco = '0;

    segment_char_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clk60        (clk60),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .msg_len      (msg_len),
        .loop         (loop),
        .start        (start),
        .stop         (stop),
        .charAvailable(charAvailable),
        .charOutput   (charOutput),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        clk60 = ~clk60;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            p60 = 1'b0;
            pca = 1'b0;
            pco = '0;
            have_rise = 0;
        end else if (enable) begin
            if (charAvailable && !pca) begin
                if (have_rise) gaps.push_back(cur_ticks);
                if (pco !== charOutput) unstable++;
                seen.push_back(charOutput);
                cur_ticks = 0;
                cur_w = 0;
                have_rise = 1;
            end
            if (clk60 && !p60) cur_ticks++;
            p60 = clk60;
            if (charAvailable) cur_w++;
            if (!charAvailable && pca) widths.push_back(cur_w);
            if (done) begin
                dones++;
                if (busy) busy_at_done++;
            end
            pca = charAvailable;
            pco = charOutput;
        end
    end

    task automatic clear_mon();
        seen.delete();
        widths.delete();
        gaps.delete();
        dones = 0;
        busy_at_done = 0;
        unstable = 0;
        have_rise = 0;
    endtask

    task automatic write_digit(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = a[2:0];
        wr_data = d[3:0];
        model_buf[a] = d[3:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_play();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (charAvailable !== 1'b0) begin errors++; $display("FAIL reset_ca got %b want 0", charAvailable); end
        checks++; if (charOutput !== 7'h00) begin errors++; $display("FAIL reset_co got %h want 00", charOutput); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) write_digit(i, i);
        msg_len = 4'd3;
        loop = 1'b0;
        clear_mon();
        start_play();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        @(negedge clk);
        checks++; if (charOutput !== 7'h3F) begin errors++; $display("FAIL basic_co_latency got %h want 3f", charOutput); end
        checks++; if (charAvailable !== 1'b0) begin errors++; $display("FAIL basic_ca_early got %b want 0", charAvailable); end
        @(negedge clk);
        checks++; if (charAvailable !== 1'b1) begin errors++; $display("FAIL basic_ca_latency got %b want 1", charAvailable); end
        for (int c = 0; c < 1400 && dones == 0; c++) @(negedge clk);
        @(negedge clk);
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL basic_count got %0d want 3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== seg_tab[i]) begin errors++; $display("FAIL basic_char%0d got %h want %h", i, seen[i], seg_tab[i]); end
        end
        for (int i = 0; i < widths.size(); i++) begin
            checks++; if (widths[i] != 4) begin errors++; $display("FAIL basic_width%0d got %0d want 4", i, widths[i]); end
        end
        for (int i = 0; i < gaps.size(); i++) begin
            checks++; if (gaps[i] < 60 || gaps[i] > 61) begin errors++; $display("FAIL basic_gap%0d got %0d want 60..61", i, gaps[i]); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL basic_done got %0d want 1", dones); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL basic_busy_at_done got %0d want 0", busy_at_done); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL basic_co_stable got %0d want 0", unstable); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int len;
            int eff;
            for (int i = 0; i < 8; i++) write_digit(i, int'($urandom_range(0, 15)));
            len = (it == 0) ? 12 : int'($urandom_range(1, 15));
            eff = (len > 8) ? 8 : len;
            msg_len = len[3:0];
            loop = 1'b0;
            clear_mon();
            start_play();
            for (int c = 0; c < 400 * eff + 100 && dones == 0; c++) @(negedge clk);
            @(negedge clk);
            checks++; if (seen.size() != eff) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, seen.size(), eff); end
            for (int i = 0; i < eff && i < seen.size(); i++) begin
                checks++; if (seen[i] !== seg_tab[model_buf[i]]) begin errors++; $display("FAIL rand%0d_char%0d got %h want %h", it, i, seen[i], seg_tab[model_buf[i]]); end
            end
            checks++; if (widths.size() != eff) begin errors++; $display("FAIL rand%0d_npulses got %0d want %0d", it, widths.size(), eff); end
            for (int i = 0; i < widths.size(); i++) begin
                checks++; if (widths[i] != 4) begin errors++; $display("FAIL rand%0d_width%0d got %0d want 4", it, i, widths[i]); end
            end
            for (int i = 0; i < gaps.size(); i++) begin
                checks++; if (gaps[i] < 60 || gaps[i] > 61) begin errors++; $display("FAIL rand%0d_gap%0d got %0d want 60..61", it, i, gaps[i]); end
            end
            checks++; if (dones != 1) begin errors++; $display("FAIL rand%0d_done got %0d want 1", it, dones); end
            checks++; if (busy_at_done != 0) begin errors++; $display("FAIL rand%0d_busy_at_done got %0d want 0", it, busy_at_done); end
            checks++; if (unstable != 0) begin errors++; $display("FAIL rand%0d_co_stable got %0d want 0", it, unstable); end
        end
    endtask

    task automatic test_loop();
        logic [6:0] first_exp;
        logic [6:0] held;
        for (int i = 0; i < 3; i++) write_digit(i, i);
        msg_len = 4'd3;
        loop = 1'b1;
        clear_mon();
        first_exp = seg_tab[model_buf[0]];
        start_play();
        for (int c = 0; c < 500 && seen.size() < 1; c++) @(negedge clk);
        write_digit(0, 15);
        for (int c = 0; c < 2200 && seen.size() < 5; c++) @(negedge clk);
        checks++; if (seen.size() < 5) begin errors++; $display("FAIL loop_count got %0d want 5", seen.size()); end
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            logic [6:0] e;
            e = (i == 0) ? first_exp : seg_tab[model_buf[i % 3]];
            checks++; if (seen[i] !== e) begin errors++; $display("FAIL loop_char%0d got %h want %h", i, seen[i], e); end
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL loop_done got %0d want 0", dones); end
        @(negedge clk);
        stop = 1'b1;
        held = charOutput;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
        checks++; if (charAvailable !== 1'b0) begin errors++; $display("FAIL stop_ca got %b want 0", charAvailable); end
        checks++; if (charOutput !== held) begin errors++; $display("FAIL stop_co got %h want %h", charOutput, held); end
        repeat (3) @(negedge clk);
        checks++; if (dones != 0) begin errors++; $display("FAIL stop_done got %0d want 0", dones); end
        loop = 1'b0;
    endtask

    task automatic test_len0();
        int busy_seen;
        busy_seen = 0;
        msg_len = 4'd0;
        clear_mon();
        start_play();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL len0_busy got %0d want 0", busy_seen); end
        checks++; if (seen.size() != 0) begin errors++; $display("FAIL len0_rises got %0d want 0", seen.size()); end
        msg_len = 4'd3;
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got %b want 0", busy); end
    endtask

    task automatic test_freeze();
        logic       s_ca;
        logic [6:0] s_co;
        logic       s_busy;
        int         drift;
        drift = 0;
        for (int i = 0; i < 3; i++) write_digit(i, int'($urandom_range(0, 15)));
        msg_len = 4'd3;
        clear_mon();
        start_play();
        for (int c = 0; c < 10 && charAvailable !== 1'b1; c++) @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        s_ca = charAvailable;
        s_co = charOutput;
        s_busy = busy;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (charAvailable !== s_ca || charOutput !== s_co || busy !== s_busy || done !== 1'b0) drift++;
        end
        checks++; if (drift != 0) begin errors++; $display("FAIL freeze_outputs got %0d changes want 0", drift); end
        checks++; if (s_ca !== 1'b1) begin errors++; $display("FAIL freeze_mid_strobe got %b want 1", s_ca); end
        enable = 1'b1;
        for (int c = 0; c < 1400 && dones == 0; c++) @(negedge clk);
        @(negedge clk);
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL freeze_count got %0d want 3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== seg_tab[model_buf[i]]) begin errors++; $display("FAIL freeze_char%0d got %h want %h", i, seen[i], seg_tab[model_buf[i]]); end
        end
        for (int i = 0; i < widths.size(); i++) begin
            checks++; if (widths[i] != 4) begin errors++; $display("FAIL freeze_width%0d got %0d want 4", i, widths[i]); end
        end
        for (int i = 0; i < gaps.size(); i++) begin
            checks++; if (gaps[i] < 60 || gaps[i] > 61) begin errors++; $display("FAIL freeze_gap%0d got %0d want 60..61", i, gaps[i]); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL freeze_done got %0d want 1", dones); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) write_digit(i, i + 4);
        msg_len = 4'd3;
        clear_mon();
        start_play();
        for (int c = 0; c < 500 && (seen.size() < 1 || charAvailable !== 1'b0); c++) @(negedge clk);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (charOutput !== 7'h00) begin errors++; $display("FAIL arst_co got %h want 00", charOutput); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (charAvailable !== 1'b0) begin errors++; $display("FAIL arst_ca got %b want 0", charAvailable); end
        for (int i = 0; i < 8; i++) model_buf[i] = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        write_digit(1, 9);
        clear_mon();
        start_play();
        for (int c = 0; c < 1400 && dones == 0; c++) @(negedge clk);
        @(negedge clk);
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL arst_restart_count got %0d want 3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== seg_tab[model_buf[i]]) begin errors++; $display("FAIL arst_restart_char%0d got %h want %h", i, seen[i], seg_tab[model_buf[i]]); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL arst_restart_done got %0d want 1", dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_loop();
        test_len0();
        test_freeze();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
